// File: rtl/lsu_axi_master.sv
// lsu_axi_master: single-outstanding core memory request to AXI4-Lite.
// One read or write in flight; one response pulse per request.
module lsu_axi_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wen,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic                resp_err,
  output logic [ADDR_W-1:0]   araddr,
  output logic                arvalid,
  input  logic                arready,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rvalid,
  output logic                rready,
  output logic [ADDR_W-1:0]   awaddr,
  output logic                awvalid,
  input  logic                awready,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wvalid,
  input  logic                wready,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);

  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {
    IDLE,
    AR,
    R,
    WR,
    B,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [STRB_W-1:0] wstrb_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;
  logic              aw_done;
  logic              w_done;

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    araddr     = '0;
    arvalid    = 1'b0;
    rready     = 1'b0;
    awaddr     = '0;
    awvalid    = 1'b0;
    wdata      = '0;
    wstrb      = '0;
    wvalid     = 1'b0;
    bready     = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_wen ? WR : AR;
      end
      AR: begin
        arvalid = 1'b1;
        araddr  = addr_q;
        if (arready) state_nx = R;
      end
      R: begin
        rready = 1'b1;
        if (rvalid) state_nx = DONE;
      end
      WR: begin
        awvalid = !aw_done;
        wvalid  = !w_done;
        awaddr  = addr_q;
        wdata   = wdata_q;
        wstrb   = wstrb_q;
        // each channel is complete if it already was or handshakes now
        if ((aw_done || awready) && (w_done || wready))
          state_nx = B;
      end
      B: begin
        bready = 1'b1;
        if (bvalid) state_nx = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && req_valid) begin
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
        rdata_q <= '0;
        err_q   <= 1'b0;
      end
      if (state == R && rvalid) begin
        rdata_q <= rdata;
        err_q   <= (rresp != 2'b00);
      end
      if (state == WR) begin
        if (awvalid && awready) aw_done <= 1'b1;
        if (wvalid && wready) w_done <= 1'b1;
        if (state_nx == B) begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
        end
      end
      if (state == B && bvalid) begin
        rdata_q <= '0;
        err_q   <= (bresp != 2'b00);
      end
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb_lsu_axi_master: directed scenarios for the AXI4-Lite LSU master.
// ctl = {req_ready, arvalid, rready, awvalid, wvalid, bready, resp_valid}.
module tb_lsu_axi_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  int checks = 0;
  int errors = 0;

  logic [6:0] ctl;
  assign ctl = {req_ready, arvalid, rready, awvalid,
                wvalid, bready, resp_valid};

  always #5 clk = ~clk;

  lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_slave();
    arready = 1'b0;
    rvalid  = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    rresp   = 2'b00;
    bresp   = 2'b00;
  endtask

  task automatic put_req(input logic wen, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1;
    req_wen   = wen;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    put_req(1'b0, 32'h0, 32'h0, 4'h0);
    req_valid = 1'b0;
    clr_slave();
    rdata = 32'h0;
    repeat (2) tick();
    checks++; if (ctl !== 7'b1000000) begin errors++; $display("FAIL rst_ctl got %b exp %b", ctl, 7'b1000000); end
    checks++; if ({araddr, awaddr, wdata, wstrb} !== 100'h0) begin errors++; $display("FAIL rst_bus got %h exp 0", {araddr, awaddr, wdata, wstrb}); end
    checks++; if ({resp_rdata, resp_err} !== 33'h0) begin errors++; $display("FAIL rst_resp got %h exp 0", {resp_rdata, resp_err}); end
    rst = 1'b0;
    tick();
    rvalid = 1'b1;
    bvalid = 1'b1;
    tick();
    checks++; if (ctl !== 7'b1000000) begin errors++; $display("FAIL idle_stray got %b exp %b", ctl, 7'b1000000); end
    clr_slave();
  endtask

  task automatic test_read_zero();
    put_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    checks++; if (ctl !== 7'b0100000) begin errors++; $display("FAIL rd0_c1 got %b exp %b", ctl, 7'b0100000); end
    checks++; if (araddr !== 32'h8000_0010) begin errors++; $display("FAIL rd0_araddr got %h exp %h", araddr, 32'h8000_0010); end
    arready = 1'b1;
    tick();
    clr_slave();
    checks++; if (ctl !== 7'b0010000) begin errors++; $display("FAIL rd0_c2 got %b exp %b", ctl, 7'b0010000); end
    rvalid = 1'b1;
    rdata  = 32'hDEAD_BEEF;
    tick();
    clr_slave();
    checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL rd0_c3 got %b exp %b", ctl, 7'b0000001); end
    checks++; if ({resp_rdata, resp_err} !== {32'hDEAD_BEEF, 1'b0}) begin errors++; $display("FAIL rd0_resp got %h/%b exp deadbeef/0", resp_rdata, resp_err); end
    tick();
    checks++; if (ctl !== 7'b1000000) begin errors++; $display("FAIL rd0_c4 got %b exp %b", ctl, 7'b1000000); end
  endtask

  task automatic test_read_bp();
    logic [6:0] exp [9];
    exp = '{7'b1000000, 7'b0100000, 7'b0100000, 7'b0100000,
            7'b0100000, 7'b0010000, 7'b0010000, 7'b0010000,
            7'b0000001};
    put_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      clr_slave();
      checks++; if (ctl !== exp[c]) begin errors++; $display("FAIL rdbp_c%0d got %b exp %b", c, ctl, exp[c]); end
      if (c <= 4) begin
        checks++; if (araddr !== 32'h8000_0010) begin errors++; $display("FAIL rdbp_araddr_c%0d got %h exp %h", c, araddr, 32'h8000_0010); end
      end
      arready = (c == 4);
      rvalid  = (c == 7);
      rdata   = 32'hCAFE_F00D;
      if (c == 8) begin
        checks++; if ({resp_rdata, resp_err} !== {32'hCAFE_F00D, 1'b0}) begin errors++; $display("FAIL rdbp_resp got %h/%b exp cafef00d/0", resp_rdata, resp_err); end
      end
      tick();
    end
    clr_slave();
    checks++; if (ctl !== 7'b1000000) begin errors++; $display("FAIL rdbp_end got %b exp %b", ctl, 7'b1000000); end
  endtask

  task automatic test_write_aw_first();
    put_req(1'b1, 32'h8000_0100, 32'h1234_5678, 4'h3);
    tick();
    req_valid = 1'b0;
    checks++; if (ctl !== 7'b0001100) begin errors++; $display("FAIL wraw_c1 got %b exp %b", ctl, 7'b0001100); end
    checks++; if ({awaddr, wdata, wstrb} !== {32'h8000_0100, 32'h1234_5678, 4'h3}) begin errors++; $display("FAIL wraw_bus got %h %h %h", awaddr, wdata, wstrb); end
    awready = 1'b1;
    tick();
    clr_slave();
    checks++; if (ctl !== 7'b0000100) begin errors++; $display("FAIL wraw_c2 got %b exp %b", ctl, 7'b0000100); end
    tick();
    checks++; if (ctl !== 7'b0000100) begin errors++; $display("FAIL wraw_c3 got %b exp %b", ctl, 7'b0000100); end
    checks++; if ({wdata, wstrb} !== {32'h1234_5678, 4'h3}) begin errors++; $display("FAIL wraw_wd got %h %h", wdata, wstrb); end
    wready = 1'b1;
    tick();
    clr_slave();
    checks++; if (ctl !== 7'b0000010) begin errors++; $display("FAIL wraw_c4 got %b exp %b", ctl, 7'b0000010); end
    bvalid = 1'b1;
    tick();
    clr_slave();
    checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL wraw_c5 got %b exp %b", ctl, 7'b0000001); end
    checks++; if ({resp_rdata, resp_err} !== 33'h0) begin errors++; $display("FAIL wraw_resp got %h/%b exp 0/0", resp_rdata, resp_err); end
    tick();
  endtask

  task automatic test_write_w_first();
    put_req(1'b1, 32'h8000_0200, 32'hA5A5_0F0F, 4'hC);
    tick();
    req_valid = 1'b0;
    checks++; if (ctl !== 7'b0001100) begin errors++; $display("FAIL wrw_c1 got %b exp %b", ctl, 7'b0001100); end
    wready = 1'b1;
    tick();
    clr_slave();
    checks++; if (ctl !== 7'b0001000) begin errors++; $display("FAIL wrw_c2 got %b exp %b", ctl, 7'b0001000); end
    checks++; if (awaddr !== 32'h8000_0200) begin errors++; $display("FAIL wrw_awaddr got %h exp %h", awaddr, 32'h8000_0200); end
    awready = 1'b1;
    tick();
    clr_slave();
    checks++; if (ctl !== 7'b0000010) begin errors++; $display("FAIL wrw_c3 got %b exp %b", ctl, 7'b0000010); end
    bvalid = 1'b1;
    bresp  = 2'b10;
    tick();
    clr_slave();
    checks++; if (ctl !== 7'b0000001) begin errors++; $display("FAIL wrw_c4 got %b exp %b", ctl, 7'b0000001); end
    checks++; if ({resp_rdata, resp_err} !== {32'h0, 1'b1}) begin errors++; $display("FAIL wrw_resp got %h/%b exp 0/1", resp_rdata, resp_err); end
    tick();
  endtask

  task automatic test_reset_mid();
    put_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    arready = 1'b1;
    tick();
    clr_slave();
    checks++; if (ctl !== 7'b0010000) begin errors++; $display("FAIL rstm_inr got %b exp %b", ctl, 7'b0010000); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (ctl !== 7'b1000000) begin errors++; $display("FAIL rstm_async got %b exp %b", ctl, 7'b1000000); end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (ctl !== 7'b1000000) begin errors++; $display("FAIL rstm_post got %b exp %b", ctl, 7'b1000000); end
    put_req(1'b0, 32'h8000_0044, 32'h0, 4'h0);
    tick();
    req_valid = 1'b0;
    checks++; if ({ctl, araddr} !== {7'b0100000, 32'h8000_0044}) begin errors++; $display("FAIL rstm_ar got %b %h", ctl, araddr); end
    arready = 1'b1;
    tick();
    clr_slave();
    rvalid = 1'b1;
    rdata  = 32'h1357_9BDF;
    rresp  = 2'b11;
    tick();
    clr_slave();
    checks++; if ({ctl, resp_rdata, resp_err} !== {7'b0000001, 32'h1357_9BDF, 1'b1}) begin errors++; $display("FAIL rstm_resp got %b %h %b", ctl, resp_rdata, resp_err); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [6:0] exp [13];
    int k;
    int pulses;
    logic took;
    exp = '{7'b1000000, 7'b0100000, 7'b0010000, 7'b0000001,
            7'b1000000, 7'b0001100, 7'b0000010, 7'b0000001,
            7'b1000000, 7'b0100000, 7'b0010000, 7'b0000001,
            7'b1000000};
    k = 0;
    pulses = 0;
    arready = 1'b1; awready = 1'b1; wready = 1'b1;
    rvalid  = 1'b1; bvalid  = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      rdata = 32'h1000_0000 + c;
      case (k)
        0: put_req(1'b0, 32'h8000_0020, 32'h0, 4'h0);
        1: put_req(1'b1, 32'h8000_0024, 32'h55, 4'hF);
        2: put_req(1'b0, 32'h8000_0028, 32'h0, 4'h0);
        default: req_valid = 1'b0;
      endcase
      checks++; if (ctl !== exp[c]) begin errors++; $display("FAIL b2b_c%0d got %b exp %b", c, ctl, exp[c]); end
      if (resp_valid) pulses++;
      if (c == 1) begin
        checks++; if (araddr !== 32'h8000_0020) begin errors++; $display("FAIL b2b_ar1 got %h exp %h", araddr, 32'h8000_0020); end
      end
      if (c == 5) begin
        checks++; if ({awaddr, wdata} !== {32'h8000_0024, 32'h55}) begin errors++; $display("FAIL b2b_aw got %h %h", awaddr, wdata); end
      end
      if (c == 3) begin
        checks++; if ({resp_rdata, resp_err} !== {32'h1000_0002, 1'b0}) begin errors++; $display("FAIL b2b_r1 got %h/%b exp 10000002/0", resp_rdata, resp_err); end
      end
      if (c == 7) begin
        checks++; if ({resp_rdata, resp_err} !== 33'h0) begin errors++; $display("FAIL b2b_w got %h/%b exp 0/0", resp_rdata, resp_err); end
      end
      if (c == 11) begin
        checks++; if ({resp_rdata, resp_err} !== {32'h1000_000A, 1'b0}) begin errors++; $display("FAIL b2b_r2 got %h/%b exp 1000000a/0", resp_rdata, resp_err); end
      end
      took = req_ready && req_valid;
      tick();
      if (took) k++;
    end
    req_valid = 1'b0;
    clr_slave();
    checks++; if (pulses !== 3) begin errors++; $display("FAIL b2b_pulses got %0d exp 3", pulses); end
  endtask

  initial begin
    test_reset();
    test_read_zero();
    test_read_bp();
    test_write_aw_first();
    test_write_w_first();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
